load_store_unit: RTL and testbench

- Sits between the RV32I execute stage and the word-wide data memory.
- Accepts byte-addressed load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) through a valid/ready handshake.
- Drives the memory's single-port word interface: one of Ren/Wen per cycle, read data registered one cycle after Ren.
- Stores narrower than a word are done as read-modify-write sequences. Returns sign- or zero-extended load data and an error flag.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 39 +++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// lane masks and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4,
    ERR  = 3'd5
  } lsu_state_e;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // f3[1:0] encodes size for every legal code: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension and
// sub-word store merge into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] data_sh;

  assign sh       = {lane_i, 3'b000};
  assign byte_sel = rdata_i[sh +: 8];
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    ld_data_o = rdata_i;
    case (f3_i)
      F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data_o = {24'h0, byte_sel};
      F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data_o = {16'h0, half_sel};
      default: ld_data_o = rdata_i;
    endcase
  end

  assign mask     = ((f3_i == F3_B) ? LANE_MASK_B : LANE_MASK_H) << sh;
  assign data_sh  = {16'h0, st_data_i} << sh;
  assign merged_o = (rdata_i & ~mask) | (data_sh & mask);

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a single-port word memory; sub-word
// stores are read-modify-write. Define LSU_BOUNDS_CHECK_EN to fault word
// indices >= MEM_WORDS.
//
//   state | meaning
//   IDLE  | ready for a request; response pulse shown here
//   RD    | memory read issued
//   CAP   | load data extracted from memory word
//   MRG   | store lane merged into memory word
//   WR    | memory write issued
//   ERR   | rejected request, error response next
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 257,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic [ADDR_W-1:0] word_idx;
  logic              req_bad;
  logic [31:0]       ld_data;
  logic [31:0]       merged;

  assign word_idx = {2'b00, req_addr[ADDR_W-1:2]};
  assign req_bad  = f3_illegal(req_we, req_funct3)
                  || misaligned(req_funct3, req_addr[1:0])
                  || (BOUNDS_EN && (word_idx >= ADDR_W'(MEM_WORDS)));

  lsu_align u_align (
    .f3_i      (f3_q),
    .lane_i    (lane_q),
    .rdata_i   (mem_rdata),
    .st_data_i (wdata_q[15:0]),
    .ld_data_o (ld_data),
    .merged_o  (merged)
  );

  // wdata_q holds the raw store data until MRG overwrites it with the merged word.
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    we_d        = we_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d   = req_funct3;
          we_d   = req_we;
          lane_d = req_addr[1:0];
          addr_d = word_idx;
          if (req_bad) begin
            state_d = ERR;
          end else begin
            wdata_d = req_wdata;
            state_d = (req_we && (req_funct3 == F3_W)) ? WR : RD;
          end
        end
      end
      RD:  state_d = we_q ? MRG : CAP;
      CAP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = IDLE;
      end
      MRG: begin
        wdata_d = merged;
        state_d = WR;
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_ren   = (state_q == RD);
  assign mem_wen   = (state_q == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rdata;
  logic        mem_clear;

  logic [31:0] mem [0:511];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(257), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_wen && mem_addr < 512) mem[mem_addr[8:0]] <= mem_wdata;
      if (mem_ren) mem_rdata <= (mem_addr < 512) ? mem[mem_addr[8:0]] : 32'h0;
    end
  end

  // Issue one request, then sample #1 after each edge until rsp_valid (cycle count = latency).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output logic s_ren, output logic s_wen,
                        output logic [31:0] a, output logic [31:0] w);
    logic got;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 1'b0; lat = 99; rd = 32'h0; er = 1'b0; s_ren = 1'b0; s_wen = 1'b0; a = 32'h0; w = 32'h0;
    for (int n = 1; n <= 10; n++) begin
      if (mem_ren) begin s_ren = 1'b1; a = mem_addr; end
      if (mem_wen) begin s_wen = 1'b1; a = mem_addr; w = mem_wdata; end
      if (rsp_valid) begin lat = n; rd = rsp_rdata; er = rsp_err; got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) $display("FAIL timeout waiting rsp_valid addr=%h", addr);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    tests_run++; if ({mem_wen, mem_ren} !== 2'b00) begin tests_failed++; $display("FAIL reset_mem_en got=%b exp=00", {mem_wen, mem_ren}); end
    tests_run++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    @(negedge clk); rst = 1'b0; mem_clear = 1'b0;
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd, a, w; logic er, sr, sw;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er, sr, sw, a, w);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    tests_run++; if (sw !== 1'b1 || sr !== 1'b0) begin tests_failed++; $display("FAIL sw_mem_en got wen=%b ren=%b exp wen=1 ren=0", sw, sr); end
    tests_run++; if (a !== 32'd4 || w !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_mem_bus got=%h/%h exp=4/deadbeef", a, w); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin tests_failed++; $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", rd, er); end
    tests_run++; if (a !== 32'd4 || sw !== 1'b0) begin tests_failed++; $display("FAIL lw_addr got=%h wen=%b exp=4 wen=0", a, sw); end
  endtask

  task automatic test_byte_rmw();
    int lat; logic [31:0] rd, a, w; logic er, sr, sw;
    do_req(1'b1, 3'b010, 32'h10, 32'h11223344, lat, rd, er, sr, sw, a, w);
    do_req(1'b1, 3'b000, 32'h12, 32'h000000AA, lat, rd, er, sr, sw, a, w);
    tests_run++; if (lat !== 4) begin tests_failed++; $display("FAIL sb_latency got=%0d exp=4", lat); end
    tests_run++; if (w !== 32'h11AA3344 || sr !== 1'b1) begin tests_failed++; $display("FAIL sb_merge got=%h ren=%b exp=11aa3344 ren=1", w, sr); end
    do_req(1'b0, 3'b000, 32'h12, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (rd !== 32'hFFFFFFAA) begin tests_failed++; $display("FAIL lb_data got=%h exp=ffffffaa", rd); end
    do_req(1'b0, 3'b100, 32'h12, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (rd !== 32'h000000AA) begin tests_failed++; $display("FAIL lbu_data got=%h exp=000000aa", rd); end
    do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (rd !== 32'h00000033) begin tests_failed++; $display("FAIL lb_lane1 got=%h exp=00000033", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd, a, w; logic er, sr, sw;
    do_req(1'b1, 3'b001, 32'h16, 32'h12348001, lat, rd, er, sr, sw, a, w);
    tests_run++; if (w !== 32'h80010000 || a !== 32'd5) begin tests_failed++; $display("FAIL sh_merge got=%h@%h exp=80010000@5", w, a); end
    do_req(1'b0, 3'b001, 32'h16, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (rd !== 32'hFFFF8001) begin tests_failed++; $display("FAIL lh_data got=%h exp=ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h16, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (rd !== 32'h00008001) begin tests_failed++; $display("FAIL lhu_data got=%h exp=00008001", rd); end
    do_req(1'b0, 3'b101, 32'h14, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (rd !== 32'h00000000) begin tests_failed++; $display("FAIL lhu_low got=%h exp=00000000", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd, a, w; logic er, sr, sw;
    do_req(1'b0, 3'b010, 32'h13, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin tests_failed++; $display("FAIL err_lw_mis got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=2", er, rd, lat); end
    tests_run++; if ({sw, sr} !== 2'b00) begin tests_failed++; $display("FAIL err_lw_mem got=%b exp=00", {sw, sr}); end
    do_req(1'b1, 3'b001, 32'h01, 32'hFFFF, lat, rd, er, sr, sw, a, w);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || {sw, sr} !== 2'b00) begin tests_failed++; $display("FAIL err_sh_mis got err=%b rd=%h en=%b exp err=1 rd=0 en=00", er, rd, {sw, sr}); end
    do_req(1'b1, 3'b100, 32'h20, 32'h5, lat, rd, er, sr, sw, a, w);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || {sw, sr} !== 2'b00) begin tests_failed++; $display("FAIL err_st_f3 got err=%b rd=%h en=%b exp err=1 rd=0 en=00", er, rd, {sw, sr}); end
    do_req(1'b0, 3'b110, 32'h20, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (er !== 1'b1 || {sw, sr} !== 2'b00) begin tests_failed++; $display("FAIL err_ld_f3 got err=%b en=%b exp err=1 en=00", er, {sw, sr}); end
  endtask

  task automatic test_reset_mid_rmw();
    logic saw_wen, saw_rsp;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    saw_wen = 1'b0; saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_wen) saw_wen = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++; if (saw_wen !== 1'b0 || saw_rsp !== 1'b0) begin tests_failed++; $display("FAIL rst_mid got wen=%b rsp=%b exp 0/0", saw_wen, saw_rsp); end
    tests_run++; if (mem[4] !== 32'h11AA3344) begin tests_failed++; $display("FAIL rst_mid_mem got=%h exp=11aa3344", mem[4]); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int n1, n2; logic [31:0] rd1, rd2;
    n1 = 99; n2 = 99; rd1 = 32'h0; rd2 = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    for (int n = 1; n <= 8; n++) begin
      if (rsp_valid) begin
        n1 = n; rd1 = rsp_rdata;
        req_funct3 = 3'b100; req_addr = 32'h12;
        break;
      end
      @(posedge clk); #1;
    end
    tests_run++; if (n1 !== 3 || rd1 !== 32'h11AA3344) begin tests_failed++; $display("FAIL b2b_first got lat=%0d rd=%h exp lat=3 rd=11aa3344", n1, rd1); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++; if (rsp_valid !== 1'b0 || mem_ren !== 1'b1 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept got rsp=%b ren=%b rdy=%b exp 0/1/0", rsp_valid, mem_ren, req_ready); end
    for (int n = 1; n <= 8; n++) begin
      if (rsp_valid) begin n2 = n; rd2 = rsp_rdata; break; end
      @(posedge clk); #1;
    end
    tests_run++; if (n2 !== 3 || rd2 !== 32'h000000AA) begin tests_failed++; $display("FAIL b2b_second got lat=%0d rd=%h exp lat=3 rd=000000aa", n2, rd2); end
  endtask

  task automatic test_bounds();
    int lat; logic [31:0] rd, a, w; logic er, sr, sw;
    do_req(1'b0, 3'b010, 32'h404, 32'h0, lat, rd, er, sr, sw, a, w);
`ifdef LSU_BOUNDS_CHECK_EN
    tests_run++; if (er !== 1'b1 || sr !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("FAIL bounds_oob got err=%b ren=%b rd=%h exp err=1 ren=0 rd=0", er, sr, rd); end
`else
    tests_run++; if (er !== 1'b0 || sr !== 1'b1 || a !== 32'd257) begin tests_failed++; $display("FAIL bounds_pass got err=%b ren=%b addr=%h exp err=0 ren=1 addr=101", er, sr, a); end
`endif
    do_req(1'b0, 3'b010, 32'h400, 32'h0, lat, rd, er, sr, sw, a, w);
    tests_run++; if (er !== 1'b0 || a !== 32'd256 || lat !== 3) begin tests_failed++; $display("FAIL bounds_last got err=%b addr=%h lat=%0d exp err=0 addr=100 lat=3", er, a, lat); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_byte_rmw();
    test_half();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
